angle_normalization_sequencer: RTL and testbench
================================================

// Module: angle_normalization_sequencer
// PURPOSE
//  Parametrised successor to the single-pass angle-normalization controller. Sweeps a programmable,
//  wrapping address window of the angle-combination memory, hands each IEEE-754 angle to an
//  external normalizer over a start/done handshake and writes the result back in place.
//  Adds configurable read latency, window base/length, write-elision mode, abort and a per-angle timeout.
// PARAMETERS
//  EXP_LEN         8    exponent width; word width FW = EXP_LEN+MANTISSA_LEN+1
//  MANTISSA_LEN    23   mantissa width
//  NUM_ANGLE       20   memory depth; AW = $clog2(NUM_ANGLE), CW = $clog2(NUM_ANGLE+1)
//  MEM_RD_LAT      1    cycles from mem_rd_addr change to valid mem_rd_data (1..4)
//  TIMEOUT_CYCLES  255  max cycles waiting for norm_done before error; TW = $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clock          in   1   single clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  start          in   1   level; accepted only in IDLE
//  abort          in   1   stop sweep at next safe point
//  base_addr      in   AW  first address of window, sampled on accepted start
//  length         in   CW  angles to process, sampled on accepted start
//  elide_writes   in   1   1: skip write when result bit-equal to input; sampled on start
//  mem_rd_addr    out  AW  memory read address
//  mem_rd_data    in   FW  memory read data
//  mem_wr_addr    out  AW  memory write address
//  mem_wr_data    out  FW  memory write data
//  mem_wr_en      out  1   one-cycle write strobe
//  norm_angle     out  FW  operand to normalizer, stable from norm_start until norm_done
//  norm_start     out  1   one-cycle request pulse
//  norm_result    in   FW  normalized angle, valid with norm_done
//  norm_done      in   1   one-cycle completion pulse
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle pulse on sweep completion, abort or timeout
//  error          out  1   sticky timeout flag, cleared on next accepted start
//  processed      out  CW  angles written or elided in last/current sweep
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-sweep aborts immediately, no done pulse.
//  States: IDLE -> READ -> NORM -> WRITE -> (READ | FINISH) ; FINISH -> IDLE.
//  IDLE: start=1 -> latch base/len (len clamped to NUM_ANGLE), elide; mem_rd_addr<=base_addr, processed<=0, error<=0.
//   len==0 -> FINISH directly (done pulse, processed=0, no memory or normalizer traffic).
//  READ: wait MEM_RD_LAT cycles after address update; then norm_angle<=mem_rd_data, norm_start=1 for one cycle, -> NORM.
//  NORM: timeout counter runs; norm_done -> capture norm_result into mem_wr_data, mem_wr_addr<=mem_rd_addr, -> WRITE.
//   counter reaches TIMEOUT_CYCLES without norm_done -> error<=1, -> FINISH, no write. norm_done ignored outside NORM.
//  WRITE: one cycle; mem_wr_en=1 unless elide_writes && result==norm_angle; processed+=1 either way.
//   processed==len -> FINISH, else addr <= (addr==NUM_ANGLE-1) ? 0 : addr+1, -> READ.
//  FINISH: done=1 one cycle, busy drops next cycle, -> IDLE; processed holds until next start.
//  abort: sampled every cycle while busy; honoured only at entry to READ (current angle always completes
//   and writes) -> FINISH. abort in NORM waits for norm_done or timeout. abort in IDLE ignored.
//  start while busy ignored. Simultaneous norm_done and timeout expiry: norm_done wins.
//  Per-angle latency: MEM_RD_LAT + 1 + normalizer latency + 1 cycles; no overlap between angles.
//  Wrap: window crossing NUM_ANGLE-1 continues at 0; no address ever >= NUM_ANGLE.
// TESTING
//  1 NUM_ANGLE=20, base=0, len=20, normalizer lat 3, adds 0 -> 20 writes, addrs 0..19, done once, processed=20.
//  2 base=18, len=4 -> writes at 18,19,0,1 in order; processed=4; no access to 2..17.
//  3 len=0 -> done 2 cycles after start, no mem_wr_en, no norm_start; len=25 -> clamps, processed=20.
//  4 elide_writes=1, normalizer returns input for even addrs -> mem_wr_en only at odd addrs, processed=len.
//  5 normalizer never answers at addr 5, TIMEOUT_CYCLES=255 -> error=1 after 255 cycles in NORM, done, processed=5.
//  6 abort during NORM at addr 3 -> addr 3 written, done next READ boundary, processed=4; reset_n low mid-sweep -> all outputs 0.

Source files
------------

// File: rtl/angle_normalization_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : angle_normalization_sequencer_if
//  Purpose  : Memory port and normalizer handshake bundle for the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
interface angle_normalization_sequencer_if #(
    parameter int FW = 32,
    parameter int AW = 5
);
    logic [AW-1:0] mem_rd_addr;
    logic [FW-1:0] mem_rd_data;
    logic [AW-1:0] mem_wr_addr;
    logic [FW-1:0] mem_wr_data;
    logic          mem_wr_en;
    logic [FW-1:0] norm_angle;
    logic          norm_start;
    logic [FW-1:0] norm_result;
    logic          norm_done;

    modport master (
        output mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en, norm_angle, norm_start,
        input  mem_rd_data, norm_result, norm_done
    );

    modport slave (
        input  mem_rd_addr, mem_wr_addr, mem_wr_data, mem_wr_en, norm_angle, norm_start,
        output mem_rd_data, norm_result, norm_done
    );
endinterface
`default_nettype wire

// File: rtl/angle_normalization_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : angle_normalization_sequencer
//  Purpose  : Sweeps a wrapping window of the angle memory through an external
//             normalizer and writes each result back in place.
//  Revision : 1.0  initial release
// ============================================================================
module angle_normalization_sequencer #(
    parameter int EXP_LEN        = 8,
    parameter int MANTISSA_LEN   = 23,
    parameter int NUM_ANGLE      = 20,
    parameter int MEM_RD_LAT     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                               clock,
    input  wire logic                               reset_n,
    input  wire logic                               start,
    input  wire logic                               abort,
    input  wire logic [$clog2(NUM_ANGLE)-1:0]       base_addr,
    input  wire logic [$clog2(NUM_ANGLE+1)-1:0]     length,
    input  wire logic                               elide_writes,
    angle_normalization_sequencer_if.master         bus,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error,
    output logic [$clog2(NUM_ANGLE+1)-1:0]          processed
);

    localparam int c_FW = EXP_LEN + MANTISSA_LEN + 1;
    localparam int c_AW = $clog2(NUM_ANGLE);
    localparam int c_CW = $clog2(NUM_ANGLE + 1);
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_LW = $clog2(MEM_RD_LAT + 1);

    localparam logic [c_AW-1:0] c_LAST_ADDR = c_AW'(NUM_ANGLE - 1);
    localparam logic [c_AW-1:0] c_ADDR_ONE  = c_AW'(1);
    localparam logic [c_AW-1:0] c_ADDR_SPAN = c_AW'(NUM_ANGLE);
    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(NUM_ANGLE);
    localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
    localparam logic [c_TW-1:0] c_TO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TO_ONE    = c_TW'(1);
    localparam logic [c_LW-1:0] c_LAT       = c_LW'(MEM_RD_LAT);
    localparam logic [c_LW-1:0] c_LAT_ONE   = c_LW'(1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_READ   = 3'd1;
    localparam logic [2:0] c_S_NORM   = 3'd2;
    localparam logic [2:0] c_S_WRITE  = 3'd3;
    localparam logic [2:0] c_S_FINISH = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [c_AW-1:0] r_rd_addr;
    logic [c_AW-1:0] r_wr_addr;
    logic [c_FW-1:0] r_wr_data;
    logic            r_wr_req;
    logic [c_FW-1:0] r_norm_angle;
    logic [c_CW-1:0] r_len;
    logic [c_CW-1:0] r_processed;
    logic            r_elide;
    logic            r_error;
    logic            r_abort_pend;
    logic [c_LW-1:0] r_lat_cnt;
    logic [c_TW-1:0] r_to_cnt;

    logic [c_AW-1:0] w_base;
    logic [c_CW-1:0] w_len_clamp;
    logic [c_CW-1:0] w_proc_inc;
    logic [c_AW-1:0] w_addr_next;
    logic            w_last_angle;
    logic            w_norm_start;
    logic            w_mem_wr_en;

    // An out-of-range base folds back into the window so no address reaches NUM_ANGLE.
    assign w_base       = (int'(base_addr) >= NUM_ANGLE) ? (base_addr - c_ADDR_SPAN) : base_addr;
    assign w_len_clamp  = (int'(length) > NUM_ANGLE) ? c_CNT_MAX : length;
    assign w_proc_inc   = r_processed + c_CNT_ONE;
    assign w_addr_next  = (r_rd_addr == c_LAST_ADDR) ? '0 : (r_rd_addr + c_ADDR_ONE);
    assign w_last_angle = (w_proc_inc == r_len) || r_abort_pend || abort;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (start) begin
                    w_state_next = (w_len_clamp == '0) ? c_S_FINISH : c_S_READ;
                end
            end
            c_S_READ: begin
                if (r_lat_cnt == c_LAT) begin
                    w_state_next = c_S_NORM;
                end
            end
            c_S_NORM: begin
                // A completion arriving on the expiry cycle still counts.
                if (bus.norm_done) begin
                    w_state_next = c_S_WRITE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_next = c_S_FINISH;
                end
            end
            c_S_WRITE:  w_state_next = w_last_angle ? c_S_FINISH : c_S_READ;
            c_S_FINISH: w_state_next = c_S_IDLE;
            default:    w_state_next = c_S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != c_S_IDLE);
        done         = (r_state == c_S_FINISH);
        w_norm_start = (r_state == c_S_NORM) && (r_to_cnt == '0);
        w_mem_wr_en  = (r_state == c_S_WRITE) && r_wr_req;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_addr    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wr_req     <= 1'b0;
            r_norm_angle <= '0;
            r_len        <= '0;
            r_processed  <= '0;
            r_elide      <= 1'b0;
            r_error      <= 1'b0;
            r_abort_pend <= 1'b0;
            r_lat_cnt    <= '0;
            r_to_cnt     <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_rd_addr    <= w_base;
                        r_len        <= w_len_clamp;
                        r_elide      <= elide_writes;
                        r_processed  <= '0;
                        r_error      <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_lat_cnt    <= '0;
                    end
                end
                c_S_READ: begin
                    if (r_lat_cnt == c_LAT) begin
                        r_norm_angle <= bus.mem_rd_data;
                        r_to_cnt     <= '0;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_LAT_ONE;
                    end
                end
                c_S_NORM: begin
                    if (bus.norm_done) begin
                        r_wr_data <= bus.norm_result;
                        r_wr_addr <= r_rd_addr;
                        r_wr_req  <= !(r_elide && (bus.norm_result == r_norm_angle));
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_error <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end
                end
                c_S_WRITE: begin
                    r_processed <= w_proc_inc;
                    if (!w_last_angle) begin
                        r_rd_addr <= w_addr_next;
                        r_lat_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase

            // Abort is remembered and acted on at the next angle boundary.
            if ((r_state != c_S_IDLE) && abort) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign bus.mem_rd_addr = r_rd_addr;
    assign bus.mem_wr_addr = r_wr_addr;
    assign bus.mem_wr_data = r_wr_data;
    assign bus.mem_wr_en   = w_mem_wr_en;
    assign bus.norm_angle  = r_norm_angle;
    assign bus.norm_start  = w_norm_start;
    assign error           = r_error;
    assign processed       = r_processed;

endmodule
`default_nettype wire

// File: tb/tb_angle_normalization_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_angle_normalization_sequencer
//  Purpose  : Randomized scoreboard bench with memory and normalizer models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_angle_normalization_sequencer;
    localparam int c_NUM = 20;
    localparam int c_LAT = 2;
    localparam int c_TO  = 255;
    localparam int c_FW  = 32;
    localparam int c_AW  = 5;
    localparam int c_CW  = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic elide_writes = 1'b0;
    logic [c_AW-1:0] base_addr = '0;
    logic [c_CW-1:0] length = '0;
    logic busy, done, error;
    logic [c_CW-1:0] processed;

    angle_normalization_sequencer_if #(.FW(c_FW), .AW(c_AW)) bus ();

    angle_normalization_sequencer #(
        .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_ANGLE(c_NUM),
        .MEM_RD_LAT(c_LAT), .TIMEOUT_CYCLES(c_TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .elide_writes(elide_writes),
        .bus(bus), .busy(busy), .done(done), .error(error), .processed(processed)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in for the external normalizer: optionally identity on even operands.
    function automatic logic [31:0] nf(input logic [31:0] x, input bit ident);
        return (ident && !x[0]) ? x : (x ^ 32'h0040_0101);
    endfunction

    // ---------------- memory world ----------------
    logic [31:0] mem      [c_NUM];
    logic [31:0] load_img [c_NUM];
    logic [31:0] rd_pipe  [c_LAT];
    bit load_req = 1'b0;

    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < c_NUM; i++) mem[i] <= load_img[i];
        end else if (bus.mem_wr_en === 1'b1 && int'(bus.mem_wr_addr) < c_NUM) begin
            mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end
        rd_pipe[0] <= (int'(bus.mem_rd_addr) < c_NUM) ? mem[bus.mem_rd_addr] : 32'hDEAD_BEEF;
        for (int i = 1; i < c_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_rd_data = rd_pipe[c_LAT-1];

    // ---------------- normalizer model ----------------
    int nz_lat = 3, nz_hang = -1, sweep_id = 0;
    bit nz_ident = 1'b0, spurious_req = 1'b0;
    int nz_cnt = 0, nz_k = 0, nz_id = 0;
    logic [31:0] nz_op = '0;

    initial begin
        bus.norm_done   = 1'b0;
        bus.norm_result = '0;
    end

    always @(negedge clock) begin
        bus.norm_done = 1'b0;
        if (!reset_n) begin
            nz_cnt = 0;
        end else begin
            if (nz_id != sweep_id) begin
                nz_id = sweep_id;
                nz_k  = 0;
            end
            if (nz_cnt > 0) begin
                nz_cnt--;
                if (nz_cnt == 0) begin
                    bus.norm_done   = 1'b1;
                    bus.norm_result = nf(nz_op, nz_ident);
                end
            end else if (spurious_req) begin
                bus.norm_done   = 1'b1;
                bus.norm_result = 32'hFFFF_FFFF;
            end
            if (bus.norm_start === 1'b1) begin
                nz_op = bus.norm_angle;
                if (nz_k != nz_hang) nz_cnt = nz_lat;
                nz_k++;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { int proc; bit err; int starts; } fin_t;
    wr_t  exp_wr_q [$];
    fin_t exp_fin_q [$];
    int starts_total = 0, starts_base = 0, dones_seen = 0;
    bit mon_off = 1'b0;

    always @(negedge clock) begin
        wr_t  w;
        fin_t f;
        if (!reset_n || mon_off) begin
            starts_base = starts_total;
        end else begin
            if (bus.norm_start === 1'b1) starts_total++;
            if (bus.mem_wr_en !== 1'b0) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected_write", 64'(bus.mem_wr_addr), 64'hFFFF);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", 64'(bus.mem_wr_addr), 64'(w.addr));
                    check("wr_data", 64'(bus.mem_wr_data), 64'(w.data));
                end
            end
            if (done !== 1'b0) begin
                dones_seen++;
                if (exp_fin_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'd0);
                end else begin
                    f = exp_fin_q.pop_front();
                    check("processed_at_done", 64'(processed), 64'(f.proc));
                    check("error_at_done", 64'(error), 64'(f.err));
                    check("norm_starts", 64'(starts_total - starts_base), 64'(f.starts));
                    check("missing_writes", 64'(exp_wr_q.size()), 64'd0);
                    exp_wr_q.delete();
                end
                starts_base = starts_total;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_mem(input bit parity);
        for (int i = 0; i < c_NUM; i++) begin
            load_img[i] = $urandom;
            if (parity) load_img[i][0] = i[0];
        end
        load_req = 1'b1;
        @(posedge clock); #1;
        load_req = 1'b0;
    endtask

    task automatic run_sweep(input int b, input int l, input bit el, input int lat,
                             input int hang, input int ab, input bit ident);
        int n, proc, starts, a, cyc, d0;
        bit err;
        logic [31:0] x, r;
        nz_lat = lat; nz_hang = hang; nz_ident = ident; sweep_id++;
        n = (l > c_NUM) ? c_NUM : l;
        proc = 0; err = 1'b0; starts = 0;
        for (int k = 0; k < n; k++) begin
            a = (b + k) % c_NUM;
            starts++;
            if (k == hang) begin err = 1'b1; break; end
            x = mem[a];
            r = nf(x, ident);
            if (!(el && r == x)) exp_wr_q.push_back('{a, r});
            proc++;
            if (k == ab) break;
        end
        exp_fin_q.push_back('{proc, err, starts});

        spurious_req = 1'b1;
        @(posedge clock); #1;
        spurious_req = 1'b0;
        base_addr = c_AW'(b); length = c_CW'(l); elide_writes = el; start = 1'b1;
        d0 = dones_seen;
        @(posedge clock); #1;
        start = 1'b0;
        if (ab >= 0) begin
            cyc = 0;
            while (cyc < 3000 && (starts_total - starts_base) < ab + 1 && dones_seen == d0) begin
                @(posedge clock); #1; cyc++;
            end
            abort = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0;
        end
        cyc = 0;
        while (dones_seen == d0 && cyc < 3000) begin
            @(posedge clock); #1; cyc++;
        end
        if (dones_seen == d0) begin
            check("done_timeout", 64'd0, 64'd1);
            exp_wr_q.delete();
            exp_fin_q.delete();
        end else begin
            if (l == 0) check("len0_done_latency", 64'(cyc <= 2), 64'd1);
            @(posedge clock); #1;
            check("busy_after_done", 64'(busy), 64'd0);
            check("processed_hold", 64'(processed), 64'(proc));
            check("error_hold", 64'(error), 64'(err));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    64'(busy), 64'd0);
        check({tag, "_done"},    64'(done), 64'd0);
        check({tag, "_error"},   64'(error), 64'd0);
        check({tag, "_proc"},    64'(processed), 64'd0);
        check({tag, "_wr_en"},   64'(bus.mem_wr_en), 64'd0);
        check({tag, "_nstart"},  64'(bus.norm_start), 64'd0);
        check({tag, "_rd_addr"}, 64'(bus.mem_rd_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(bus.mem_wr_data), 64'd0);
        check({tag, "_angle"},   64'(bus.norm_angle), 64'd0);
    endtask

    initial begin
        int b, l, n, ab;
        bit el, id;
        #2;
        check_all_zero("reset");
        @(posedge clock); #1;
        reset_n = 1'b1;

        load_mem(1'b0);
        run_sweep(0, 20, 1'b0, 3, -1, -1, 1'b0);   // full window
        run_sweep(18, 4, 1'b0, 2, -1, -1, 1'b0);   // wrap 18,19,0,1
        run_sweep(0, 0, 1'b0, 1, -1, -1, 1'b0);    // empty window
        run_sweep(7, 25, 1'b0, 1, -1, -1, 1'b0);   // length clamps to 20
        load_mem(1'b1);
        run_sweep(0, 20, 1'b1, 2, -1, -1, 1'b1);   // elide even addresses
        run_sweep(5, 9, 1'b0, 4, -1, -1, 1'b1);    // identity results still written
        load_mem(1'b0);
        run_sweep(0, 20, 1'b0, 2, 5, -1, 1'b0);    // normalizer hangs at addr 5
        run_sweep(0, 10, 1'b0, 3, -1, 3, 1'b0);    // abort while angle 3 in flight

        for (int i = 0; i < 10; i++) begin
            b  = $urandom_range(0, c_NUM - 1);
            l  = $urandom_range(0, 25);
            el = 1'($urandom_range(0, 1));
            id = 1'($urandom_range(0, 1));
            n  = (l > c_NUM) ? c_NUM : l;
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            if (i % 3 == 0) load_mem(id);
            run_sweep(b, l, el, $urandom_range(1, 5), -1, ab, id);
        end

        // Reset in the middle of a sweep: everything clears, no done pulse.
        mon_off = 1'b1;
        nz_lat = 3; nz_hang = -1; sweep_id++;
        base_addr = '0; length = c_CW'(20); elide_writes = 1'b0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (30) begin @(posedge clock); #1; end
        check("busy_before_reset", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_wr_q.delete();
        exp_fin_q.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        mon_off = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        check("idle_after_reset", 64'(busy), 64'd0);
        run_sweep(3, 6, 1'b0, 2, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
